// File: rtl/fixed_divider_p.sv
// Sequential radix-2 restoring fixed-point divider, q = a/b in Q(WIDTH-FRAC).FRAC.
// One quotient bit per clock, optional two's-complement mode with saturation.
module fixed_divider_p #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned FRAC   = 6,
    parameter bit          SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] q_out,
    output logic             dvz,
    output logic             ovf,
    output logic             busy,
    output logic             valid
);

    localparam int unsigned N  = WIDTH + FRAC;
    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [N-1:0]     PosLim = N'((1 << (WIDTH - 1)) - 1);
    localparam logic [N-1:0]     NegLim = PosLim + N'(1);
    localparam logic [WIDTH-1:0] QMax   = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] QMin   = {1'b1, {(WIDTH - 1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     dq_q, dq_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dvz_q, dvz_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [N-1:0]     dvd_init;
    logic [WIDTH:0]   r_sh, r_trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;
    logic [N-1:0]     dq_nxt;
    logic             ovf_fin;
    logic [WIDTH-1:0] q_fin;

    // Unsigned WIDTH-bit magnitude: -2^(WIDTH-1) negates to 2^(WIDTH-1) without wrapping.
    always_comb begin
        a_mag = (SIGNED && a_in[WIDTH-1]) ? (~a_in + 1'b1) : a_in;
        b_mag = (SIGNED && b_in[WIDTH-1]) ? (~b_in + 1'b1) : b_in;
        dvd_init = '0;
        dvd_init[N-1 -: WIDTH] = a_mag;
    end

    // dq holds the unconsumed dividend bits on top and the growing quotient below.
    always_comb begin
        r_sh    = {rem_q, dq_q[N-1]};
        r_trial = r_sh - {1'b0, div_q};
        q_bit   = ~r_trial[WIDTH];
        rem_nxt = q_bit ? r_trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
        dq_nxt  = {dq_q[N-2:0], q_bit};
    end

    always_comb begin
        ovf_fin = 1'b0;
        q_fin   = dq_nxt[WIDTH-1:0];
        if (SIGNED) begin
            if (neg_q) begin
                ovf_fin = dq_nxt > NegLim;
                q_fin   = ovf_fin ? QMin : (~dq_nxt[WIDTH-1:0] + 1'b1);
            end else begin
                ovf_fin = dq_nxt > PosLim;
                q_fin   = ovf_fin ? QMax : dq_nxt[WIDTH-1:0];
            end
        end else begin
            ovf_fin = (dq_nxt >> WIDTH) != '0;
            q_fin   = ovf_fin ? '1 : dq_nxt[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        div_d   = div_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        dvz_d   = dvz_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    valid_d = 1'b0;
                    dvz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    if (b_in == '0) begin
                        state_d = StDone;
                        valid_d = 1'b1;
                        dvz_d   = 1'b1;
                        q_d     = '0;
                    end else begin
                        state_d = StCalc;
                        dq_d    = dvd_init;
                        rem_d   = '0;
                        div_d   = b_mag;
                        neg_d   = SIGNED && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        cnt_d   = '0;
                    end
                end
            end
            StCalc: begin
                dq_d  = dq_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    q_d     = q_fin;
                    ovf_d   = ovf_fin;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= StIdle;
            dq_q    <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            q_q     <= '0;
            dvz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            dvz_q   <= dvz_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign q_out = q_q;
    assign dvz   = dvz_q;
    assign ovf   = ovf_q;
    assign valid = valid_q;
    assign busy  = state_q == StCalc;

endmodule

// File: tb/tb_fixed_divider_p.sv
// Directed bench for fixed_divider_p: one unsigned and one signed instance (WIDTH=10, FRAC=6).
module tb_fixed_divider_p;

    logic       clk = 1'b0;
    logic       sclr;
    logic       start;
    logic       sel;
    logic [9:0] a, b;
    logic [9:0] q_u, q_s;
    logic       dvz_u, ovf_u, busy_u, valid_u;
    logic       dvz_s, ovf_s, busy_s, valid_s;
    logic [9:0] q_m;
    logic       dvz_m, ovf_m, busy_m, valid_m;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    fixed_divider_p #(.WIDTH(10), .FRAC(6), .SIGNED(1'b0)) u_dut_u (
        .clk   (clk),
        .sclr  (sclr),
        .start (start & ~sel),
        .a_in  (a),
        .b_in  (b),
        .q_out (q_u),
        .dvz   (dvz_u),
        .ovf   (ovf_u),
        .busy  (busy_u),
        .valid (valid_u)
    );

    fixed_divider_p #(.WIDTH(10), .FRAC(6), .SIGNED(1'b1)) u_dut_s (
        .clk   (clk),
        .sclr  (sclr),
        .start (start & sel),
        .a_in  (a),
        .b_in  (b),
        .q_out (q_s),
        .dvz   (dvz_s),
        .ovf   (ovf_s),
        .busy  (busy_s),
        .valid (valid_s)
    );

    assign q_m     = sel ? q_s     : q_u;
    assign dvz_m   = sel ? dvz_s   : dvz_u;
    assign ovf_m   = sel ? ovf_s   : ovf_u;
    assign busy_m  = sel ? busy_s  : busy_u;
    assign valid_m = sel ? valid_s : valid_u;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_q"}, 32'(q_m), 32'd0);
        check({tag, "_dvz"}, 32'(dvz_m), 32'd0);
        check({tag, "_ovf"}, 32'(ovf_m), 32'd0);
        check({tag, "_busy"}, 32'(busy_m), 32'd0);
        check({tag, "_valid"}, 32'(valid_m), 32'd0);
    endtask

    // mode 1: scramble operands mid-run; mode 2: re-pulse start (with b=0) while busy.
    task automatic run(input string tag, input bit s, input logic [9:0] av, input logic [9:0] bv,
                       input int mode, input logic [9:0] eq, input logic eovf,
                       input logic edvz);
        int cnt;
        sel = s;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy0"}, 32'(busy_m), 32'(bv != 10'd0));
        cnt = 0;
        while (!valid_m && cnt < 40) begin
            @(negedge clk);
            if (mode == 1 && cnt == 3) begin
                a = 10'h155;
                b = 10'h001;
            end
            start = (mode == 2 && cnt == 4);
            if (mode == 2 && cnt == 4) b = 10'd0;
            @(posedge clk);
            #1;
            cnt++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 32'(cnt), (bv == 10'd0) ? 32'd0 : 32'd16);
        check({tag, "_valid"}, 32'(valid_m), 32'd1);
        check({tag, "_busy"}, 32'(busy_m), 32'd0);
        check({tag, "_q"}, 32'(q_m), 32'(eq));
        check({tag, "_ovf"}, 32'(ovf_m), 32'(eovf));
        check({tag, "_dvz"}, 32'(dvz_m), 32'(edvz));
    endtask

    initial begin
        sclr  = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        sclr = 1'b0;
        check_idle("rst_u");
        sel = 1'b1;
        #1;
        check_idle("rst_s");

        run("u720_168", 1'b0, 10'd720, 10'd168, 0, 10'd274, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("hold_valid", 32'(valid_m), 32'd1);
        check("hold_q", 32'(q_m), 32'd274);

        run("u_dvz", 1'b0, 10'd16, 10'd0, 0, 10'd0, 1'b0, 1'b1);
        run("u_ovf", 1'b0, 10'd592, 10'd8, 0, 10'h3FF, 1'b1, 1'b0);
        run("u80_392", 1'b0, 10'd80, 10'd392, 1, 10'd13, 1'b0, 1'b0);
        run("u592_136", 1'b0, 10'd592, 10'd136, 1, 10'd278, 1'b0, 1'b0);
        run("u_zero_a", 1'b0, 10'd0, 10'd5, 0, 10'd0, 1'b0, 1'b0);
        run("u_repulse", 1'b0, 10'd720, 10'd168, 2, 10'd274, 1'b0, 1'b0);

        // Abort mid-run with sclr, then confirm a fresh run still completes.
        sel = 1'b0;
        @(negedge clk);
        a = 10'd720;
        b = 10'd168;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        sclr = 1'b1;
        @(posedge clk);
        #1;
        check_idle("abort");
        @(negedge clk);
        sclr = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_stay_valid", 32'(valid_m), 32'd0);
        check("abort_stay_busy", 32'(busy_m), 32'd0);
        run("u_after_abort", 1'b0, 10'd80, 10'd392, 0, 10'd13, 1'b0, 1'b0);

        // sclr coincident with start wins.
        @(negedge clk);
        sclr = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check_idle("sclr_start");
        start = 1'b0;
        sclr = 1'b0;

        run("s_m1_half", 1'b1, 10'h3C0, 10'd32, 0, 10'h380, 1'b0, 1'b0);
        run("s_ovf", 1'b1, 10'h200, 10'h3C0, 0, 10'h1FF, 1'b1, 1'b0);
        run("s_min_by_1", 1'b1, 10'h200, 10'd64, 0, 10'h200, 1'b0, 1'b0);
        run("s_min_min", 1'b1, 10'h200, 10'h200, 0, 10'd64, 1'b0, 1'b0);
        run("s_1p5_m1", 1'b1, 10'd96, 10'h3C0, 0, 10'h3A0, 1'b0, 1'b0);
        run("s_dvz", 1'b1, 10'h3C0, 10'd0, 0, 10'd0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
